// File: rtl/clock_pkg.sv
// Shared encodings for the smart clock configuration path: controller
// states, editable field selectors, field limits and field positions
// within the packed {hour, min, sec} time word.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_SET_TIME  = 2'b01,
    ST_SET_ALARM = 2'b10
  } conf_stat_e;

  typedef enum logic [1:0] {
    F_HOUR = 2'b00,
    F_MIN  = 2'b01,
    F_SEC  = 2'b10
  } conf_field_e;

  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] SEC_MAX  = 8'd59;

  localparam int HOUR_LSB = 16;
  localparam int MIN_LSB  = 8;
  localparam int SEC_LSB  = 0;

  // Upper limit of whichever field is being edited.
  function automatic logic [7:0] field_max(conf_field_e f);
    case (f)
      F_HOUR:  field_max = HOUR_MAX;
      F_MIN:   field_max = MIN_MAX;
      F_SEC:   field_max = SEC_MAX;
      default: field_max = HOUR_MAX;
    endcase
  endfunction

  // Field cursor order HOUR -> MIN -> SEC -> HOUR.
  function automatic conf_field_e next_field(conf_field_e f);
    case (f)
      F_HOUR:  next_field = F_MIN;
      F_MIN:   next_field = F_SEC;
      default: next_field = F_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/conf_field_step.sv
// Wrapping increment/decrement of one 8-bit time field. A value already
// outside 0..max snaps to 0 on increment and to max on decrement, so a
// corrupt live time can always be edited back into range.
module conf_field_step (
  input  logic [7:0] value_i,
  input  logic [7:0] max_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] result_o
);

  // Exactly one of inc/dec moves the value; both or neither leave it alone.
  always_comb begin
    result_o = value_i;
    if (inc_i && !dec_i) begin
      if (value_i >= max_i) result_o = 8'd0;
      else                  result_o = value_i + 8'd1;
    end else if (dec_i && !inc_i) begin
      if (value_i == 8'd0 || value_i > max_i) result_o = max_i;
      else                                    result_o = value_i - 8'd1;
    end
  end

endmodule

// File: rtl/conf_ctrl.sv
// Button-driven configuration sequencer: IDLE -> SET_TIME -> SET_ALARM ->
// IDLE. Edits one field of conf_time at a time, strobes a time load into the
// timekeeper on the first commit, latches the alarm on the second, and falls
// back to IDLE without committing after a stretch of button inactivity.
module conf_ctrl
  import clock_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000,
  parameter int          TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_sel,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] clock_time,
  output logic [1:0]  conf_stat,
  output logic [23:0] conf_time,
  output logic        conf_pulse,
  output logic [1:0]  conf_field,
  output logic        time_load,
  output logic [23:0] time_load_val,
  output logic [23:0] alarm_time,
  output logic        alarm_en
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 16'd1);

  conf_stat_e      state_q, state_d;
  conf_field_e     confField_q, confField_d;
  logic [23:0]     confTime_q, confTime_d;
  logic            confPulse_q, confPulse_d;
  logic            timeLoad_q, timeLoad_d;
  logic [23:0]     timeLoadVal_q, timeLoadVal_d;
  logic [23:0]     alarmTime_q, alarmTime_d;
  logic            alarmEn_q, alarmEn_d;
  logic [TO_W-1:0] toCnt_q, toCnt_d;

  logic [7:0]      fieldVal;
  logic [7:0]      fieldMax;
  logic [7:0]      fieldNext;
  logic [23:0]     editedTime;
  logic            anyBtn;
  logic            editBtn;

  // Pick the currently selected field out of the edited time word.
  always_comb begin
    fieldVal = confTime_q[HOUR_LSB +: 8];
    case (confField_q)
      F_HOUR:  fieldVal = confTime_q[HOUR_LSB +: 8];
      F_MIN:   fieldVal = confTime_q[MIN_LSB +: 8];
      F_SEC:   fieldVal = confTime_q[SEC_LSB +: 8];
      default: fieldVal = confTime_q[HOUR_LSB +: 8];
    endcase
    fieldMax = field_max(confField_q);
  end

  conf_field_step u_step (
    .value_i  (fieldVal),
    .max_i    (fieldMax),
    .inc_i    (btn_inc),
    .dec_i    (btn_dec),
    .result_o (fieldNext)
  );

  // Splice the stepped field back in, leaving the other two fields alone.
  always_comb begin
    editedTime = confTime_q;
    case (confField_q)
      F_HOUR:  editedTime[HOUR_LSB +: 8] = fieldNext;
      F_MIN:   editedTime[MIN_LSB +: 8]  = fieldNext;
      F_SEC:   editedTime[SEC_LSB +: 8]  = fieldNext;
      default: editedTime = confTime_q;
    endcase
  end

  assign anyBtn  = btn_mode | btn_sel | btn_inc | btn_dec;
  assign editBtn = btn_inc ^ btn_dec;

  // Next-state and output decode; mode outranks sel, which outranks inc/dec.
  always_comb begin
    state_d       = state_q;
    confField_d   = confField_q;
    confTime_d    = confTime_q;
    confPulse_d   = 1'b0;
    timeLoad_d    = 1'b0;
    timeLoadVal_d = timeLoadVal_q;
    alarmTime_d   = alarmTime_q;
    alarmEn_d     = alarmEn_q;
    toCnt_d       = '0;

    case (state_q)
      ST_IDLE: begin
        if (btn_mode) begin
          state_d     = ST_SET_TIME;
          confTime_d  = clock_time;
          confField_d = F_HOUR;
          confPulse_d = 1'b1;
        end else if (btn_inc) begin
          alarmEn_d = ~alarmEn_q;
        end
      end

      ST_SET_TIME, ST_SET_ALARM: begin
        if (btn_mode) begin
          confField_d = F_HOUR;
          if (state_q == ST_SET_TIME) begin
            state_d       = ST_SET_ALARM;
            timeLoad_d    = 1'b1;
            timeLoadVal_d = confTime_q;
            confTime_d    = alarmTime_q;
            confPulse_d   = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            alarmTime_d = confTime_q;
            alarmEn_d   = 1'b1;
          end
        end else if (btn_sel) begin
          confField_d = next_field(confField_q);
        end else if (editBtn) begin
          confTime_d  = editedTime;
          confPulse_d = 1'b1;
        end

        if (!anyBtn) begin
          if (toCnt_q == TO_LAST) state_d = ST_IDLE;
          else                    toCnt_d = toCnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Register every output so a button response lands one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      confField_q   <= F_HOUR;
      confTime_q    <= '0;
      confPulse_q   <= 1'b0;
      timeLoad_q    <= 1'b0;
      timeLoadVal_q <= '0;
      alarmTime_q   <= '0;
      alarmEn_q     <= 1'b0;
      toCnt_q       <= '0;
    end else begin
      state_q       <= state_d;
      confField_q   <= confField_d;
      confTime_q    <= confTime_d;
      confPulse_q   <= confPulse_d;
      timeLoad_q    <= timeLoad_d;
      timeLoadVal_q <= timeLoadVal_d;
      alarmTime_q   <= alarmTime_d;
      alarmEn_q     <= alarmEn_d;
      toCnt_q       <= toCnt_d;
    end
  end

  assign conf_stat     = state_q;
  assign conf_field    = confField_q;
  assign conf_time     = confTime_q;
  assign conf_pulse    = confPulse_q;
  assign time_load     = timeLoad_q;
  assign time_load_val = timeLoadVal_q;
  assign alarm_time    = alarmTime_q;
  assign alarm_en      = alarmEn_q;

endmodule

// File: tb/tb_conf_ctrl.sv
// Directed bench for conf_ctrl with a short timeout so inactivity abort is
// reachable quickly. Expected values are hand-computed BCD-free binary times.
module tb_conf_ctrl;

  logic        clk;
  logic        rst_n;
  logic        btnMode, btnSel, btnInc, btnDec;
  logic [23:0] clockTime;
  logic [1:0]  confStat;
  logic [23:0] confTime;
  logic        confPulse;
  logic [1:0]  confField;
  logic        timeLoad;
  logic [23:0] timeLoadVal;
  logic [23:0] alarmTime;
  logic        alarmEn;

  int compareCount  = 0;
  int mismatchCount = 0;

  conf_ctrl #(.TIMEOUT_CYCLES(16'd8), .TO_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_mode      (btnMode),
    .btn_sel       (btnSel),
    .btn_inc       (btnInc),
    .btn_dec       (btnDec),
    .clock_time    (clockTime),
    .conf_stat     (confStat),
    .conf_time     (confTime),
    .conf_pulse    (confPulse),
    .conf_field    (confField),
    .time_load     (timeLoad),
    .time_load_val (timeLoadVal),
    .alarm_time    (alarmTime),
    .alarm_en      (alarmEn)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one button cycle, leaving the bench #1 after the sampling edge.
  task automatic applyStimulus(input logic m, input logic s, input logic i,
                               input logic d);
    @(negedge clk);
    btnMode = m; btnSel = s; btnInc = i; btnDec = d;
    @(posedge clk);
    #1;
    btnMode = 1'b0; btnSel = 1'b0; btnInc = 1'b0; btnDec = 1'b0;
  endtask

  task automatic repeatStimulus(input int n, input logic m, input logic s,
                                input logic i, input logic d);
    for (int k = 0; k < n; k++) applyStimulus(m, s, i, d);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_stat"},  32'(confStat),    32'h0);
    checkOutput({tag, "_time"},  32'(confTime),    32'h0);
    checkOutput({tag, "_pulse"}, 32'(confPulse),   32'h0);
    checkOutput({tag, "_field"}, 32'(confField),   32'h0);
    checkOutput({tag, "_tl"},    32'(timeLoad),    32'h0);
    checkOutput({tag, "_tlv"},   32'(timeLoadVal), 32'h0);
    checkOutput({tag, "_alarm"}, 32'(alarmTime),   32'h0);
    checkOutput({tag, "_aen"},   32'(alarmEn),     32'h0);
  endtask

  logic tlSeen;

  initial begin
    rst_n = 1'b0;
    btnMode = 1'b0; btnSel = 1'b0; btnInc = 1'b0; btnDec = 1'b0;
    clockTime = 24'h0C2238;
    #12;
    checkResetValues("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Enter SET_TIME from 12:34:56.
    applyStimulus(1, 0, 0, 0);
    checkOutput("enter_stat",  32'(confStat),  32'h1);
    checkOutput("enter_time",  32'(confTime),  32'h0C2238);
    checkOutput("enter_pulse", 32'(confPulse), 32'h1);
    checkOutput("enter_field", 32'(confField), 32'h0);
    @(posedge clk); #1;
    checkOutput("enter_pulse_off", 32'(confPulse), 32'h0);

    // Hour 12 -> 23, then wrap to 0.
    repeatStimulus(11, 0, 0, 1, 0);
    checkOutput("hour23", 32'(confTime), 32'h172238);
    applyStimulus(0, 0, 1, 0);
    checkOutput("hour_wrap",  32'(confTime),  32'h002238);
    checkOutput("hour_pulse", 32'(confPulse), 32'h1);

    // To SEC, sec 56 -> 0 via 59, then dec from 0 wraps to 59.
    repeatStimulus(2, 0, 1, 0, 0);
    checkOutput("field_sec", 32'(confField), 32'h2);
    repeatStimulus(4, 0, 0, 1, 0);
    checkOutput("sec_wrap_inc", 32'(confTime), 32'h002200);
    applyStimulus(0, 0, 0, 1);
    checkOutput("sec_wrap_dec", 32'(confTime), 32'h00223B);

    // Build 07:00:00.
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("field_wrap_hour", 32'(confField), 32'h0);
    repeatStimulus(7, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    repeatStimulus(26, 0, 0, 1, 0);
    checkOutput("time_0700", 32'(confTime), 32'h070000);

    // inc+dec together is a no-op.
    applyStimulus(0, 0, 1, 1);
    checkOutput("incdec_time",  32'(confTime),  32'h070000);
    checkOutput("incdec_pulse", 32'(confPulse), 32'h0);

    // Commit time.
    applyStimulus(1, 0, 0, 0);
    checkOutput("commit_tl",    32'(timeLoad),    32'h1);
    checkOutput("commit_tlv",   32'(timeLoadVal), 32'h070000);
    checkOutput("commit_stat",  32'(confStat),    32'h2);
    checkOutput("commit_time",  32'(confTime),    32'h000000);
    checkOutput("commit_pulse", 32'(confPulse),   32'h1);
    @(posedge clk); #1;
    checkOutput("commit_tl_off", 32'(timeLoad), 32'h0);

    // Alarm 06:30:00: hour 0 -> 23 -> 6, min 0 -> 30.
    applyStimulus(0, 0, 0, 1);
    checkOutput("alarm_hour_wrap", 32'(confTime), 32'h170000);
    repeatStimulus(17, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    repeatStimulus(30, 0, 0, 1, 0);
    checkOutput("alarm_edit", 32'(confTime), 32'h061E00);
    applyStimulus(1, 0, 0, 0);
    checkOutput("alarm_commit_time", 32'(alarmTime), 32'h061E00);
    checkOutput("alarm_commit_en",   32'(alarmEn),   32'h1);
    checkOutput("alarm_commit_stat", 32'(confStat),  32'h0);
    checkOutput("alarm_commit_tl",   32'(timeLoad),  32'h0);

    // inc in IDLE toggles alarm_en.
    applyStimulus(0, 0, 1, 0);
    checkOutput("idle_toggle", 32'(alarmEn), 32'h0);

    // Inactivity timeout after 8 cycles in SET_TIME.
    clockTime = 24'h010203;
    applyStimulus(1, 0, 0, 0);
    tlSeen = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      tlSeen = tlSeen | timeLoad;
    end
    checkOutput("to_before", 32'(confStat), 32'h1);
    @(posedge clk); #1;
    tlSeen = tlSeen | timeLoad;
    checkOutput("to_stat",   32'(confStat),  32'h0);
    checkOutput("to_noload", 32'(tlSeen),    32'h0);
    checkOutput("to_alarm",  32'(alarmTime), 32'h061E00);
    checkOutput("to_time",   32'(confTime),  32'h010203);

    // Out-of-range live time 30:64:80 snaps into range.
    clockTime = 24'h1E4050;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("oor_hour_inc", 32'(confTime), 32'h004050);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("oor_min_dec", 32'(confTime), 32'h003B50);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("oor_sec_inc", 32'(confTime), 32'h003B00);
    applyStimulus(1, 0, 0, 0);
    checkOutput("oor_commit_tlv", 32'(timeLoadVal), 32'h003B00);
    applyStimulus(1, 0, 0, 0);
    checkOutput("oor_alarm_en", 32'(alarmEn), 32'h1);

    // mode+inc commits without incrementing the hour.
    clockTime = 24'h0A0B0C;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0);
    checkOutput("modeinc_tl",   32'(timeLoad),    32'h1);
    checkOutput("modeinc_tlv",  32'(timeLoadVal), 32'h0A0B0C);
    checkOutput("modeinc_stat", 32'(confStat),    32'h2);
    checkOutput("modeinc_time", 32'(confTime),    32'h061E00);

    // Asynchronous reset in the middle of SET_ALARM.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetValues("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_tl",   32'(timeLoad), 32'h0);
    checkOutput("post_rst_stat", 32'(confStat), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/conf_ctrl.md
Name: conf_ctrl

Overview:
- Button-driven configuration sequencer for the smart clock.
- Owns conf_stat and conf_time, which the display mux consumes: time-of-day when idle, conf_time while configuring.
- Walks the user through setting the time, then the alarm, one hour/min/sec field at a time.
- Issues a one-cycle load of the new time to the timekeeping counter and holds the alarm registers.

Parameters:
- TIMEOUT_CYCLES, 16'd60000: idle cycles with no button activity before configuration aborts without commit.
- TO_W, 16: width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_mode  in  1  debounced single-cycle pulse: enter, advance or commit mode
- btn_sel  in  1  debounced pulse: advance field HOUR->MIN->SEC->HOUR
- btn_inc  in  1  debounced pulse: increment the selected field; in IDLE, toggles alarm_en
- btn_dec  in  1  debounced pulse: decrement the selected field
- clock_time  in  24  live time {hour[23:16], min[15:8], sec[7:0]}, binary
- conf_stat  out  2  00 IDLE, 01 SET_TIME, 10 SET_ALARM; 11 never driven
- conf_time  out  24  value being edited, same field layout as clock_time
- conf_pulse  out  1  one-cycle strobe whenever conf_time is written
- conf_field  out  2  00 HOUR, 01 MIN, 10 SEC
- time_load  out  1  one-cycle strobe: timekeeper loads time_load_val
- time_load_val  out  24  committed time, valid while time_load=1
- alarm_time  out  24  committed alarm time
- alarm_en  out  1  alarm armed

Behaviour:
- Reset values (async on rst_n low): conf_stat=00, conf_time=0, conf_pulse=0, conf_field=00, time_load=0, time_load_val=0, alarm_time=0, alarm_en=0, timeout counter=0.
- All outputs are registered; the response to a button appears on the cycle after the pulse is sampled.
- Button priority when pulses coincide: btn_mode > btn_sel > inc/dec.
  - Only the highest-priority action executes.
  - btn_inc and btn_dec together, with no mode/sel: no change, no conf_pulse.
- IDLE:
  - btn_mode -> SET_TIME; conf_time<=clock_time; conf_field<=HOUR; conf_pulse=1.
  - btn_inc toggles alarm_en.
  - btn_sel and btn_dec are ignored.
- SET_TIME:
  - btn_sel advances conf_field, wrapping SEC->HOUR.
  - btn_inc/btn_dec modify the selected field and pulse conf_pulse.
  - btn_mode commits: time_load=1 for one cycle, time_load_val<=conf_time. Then go to SET_ALARM with conf_time<=alarm_time, conf_field<=HOUR, conf_pulse=1.
- SET_ALARM:
  - Same editing rules as SET_TIME.
  - btn_mode commits: alarm_time<=conf_time, alarm_en<=1, go to IDLE. No time_load.
- Field arithmetic:
  - Hour range is 0..23; min and sec range is 0..59.
  - inc at max wraps to 0; dec at 0 wraps to max.
  - A field holding an out-of-range value goes to 0 on inc and to max on dec.
  - Other fields are untouched.
- Timeout:
  - The counter clears on any button pulse and on every state change, and increments otherwise while not IDLE.
  - On reaching TIMEOUT_CYCLES-1, go to IDLE the next cycle. No commit, no time_load, alarm_time unchanged.
  - In IDLE the counter holds 0.
- conf_time is not tracked to clock_time in IDLE; it holds its last value.
- Reset mid-configuration returns to IDLE immediately with all reset values. A pending commit is lost.
- time_load is never asserted in the same cycle as a reset deassertion.

Decomposition:
- Package clock_pkg:
  - conf_stat encodings (ST_IDLE, ST_SET_TIME, ST_SET_ALARM)
  - field encodings (F_HOUR, F_MIN, F_SEC)
  - HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59
  - field bit-slice positions
- Sub-module conf_field_step:
  - combinational; inputs are 8-bit value, max, inc, dec; output is the wrapped result
  - instantiated once, muxed by conf_field
- Top-level conf_ctrl holds the FSM, the timeout counter and the output registers.

Test Plan:
- Reset with clock_time=12:34:56, pulse btn_mode -> next cycle conf_stat=01, conf_time=0C2238, conf_pulse=1 for exactly one cycle, conf_field=00.
- In SET_TIME, hour=23, btn_inc -> hour=0, min/sec unchanged. btn_sel twice, then btn_dec with sec=0 -> sec=59.
- Edit to 07:00:00, btn_mode -> one-cycle time_load=1 with time_load_val=070000. conf_stat=10 and conf_time=alarm_time (000000 after reset).
- In SET_ALARM, set 06:30:00, btn_mode -> alarm_time=061E00, alarm_en=1, conf_stat=00. Then btn_inc in IDLE -> alarm_en=0.
- With TIMEOUT_CYCLES=8, enter SET_TIME and send no buttons -> conf_stat=00 after 8 cycles; time_load never asserts and alarm_time is unchanged.
- Coincident pulses:
  - btn_inc+btn_dec -> conf_time unchanged, no conf_pulse.
  - btn_mode+btn_inc in SET_TIME -> commit only; the hour is not incremented.
  - rst_n low mid-SET_ALARM -> all outputs at reset values asynchronously.
